// File: rtl/hazard_info_pipe_pkg.sv
// hazard_info_pipe_pkg
//   Shared definitions for the hazard-descriptor pipeline. It holds the
//   default field widths, the Tnew encodings, the all-zero bubble
//   descriptor and the saturating Tnew decrement used between stages.
package hazard_info_pipe_pkg;

   localparam int REG_W  = 5;
   localparam int TNEW_W = 2;

   localparam logic [TNEW_W-1:0] TNEW_0 = 2'd0;
   localparam logic [TNEW_W-1:0] TNEW_1 = 2'd1;
   localparam logic [TNEW_W-1:0] TNEW_2 = 2'd2;
   localparam logic [TNEW_W-1:0] TNEW_3 = 2'd3;

   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  writeReg;
      logic              regWrite;
      logic [TNEW_W-1:0] tnew;
   } hazDesc_t;

   // A bubble writes nothing and is ready at once, so it can never
   // cause a forward or a stall.
   localparam hazDesc_t HAZ_BUBBLE = '0;

   // Tnew counts down by one per stage and stops at 0. Wrapping to 3
   // would show a finished result as not yet produced.
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
      return (x == TNEW_0) ? TNEW_0 : x - TNEW_1;
   endfunction

endpackage

// File: rtl/hazard_info_pipe_stage_reg.sv
// hazard_stage_reg
//   One pipeline register for the {WriteReg, RegWrite, Tnew} part of a
//   hazard descriptor.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     flush                 load a bubble instead of the input
//     decEn                 store sat_dec(tnewIn) rather than tnewIn
//     writeRegIn/regWriteIn/tnewIn   descriptor from the previous stage
//     writeRegQ/regWriteQ/tnewQ      registered descriptor
module hazard_stage_reg #(
   parameter int REG_W  = 5,
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              decEn,
   input  logic [REG_W-1:0]  writeRegIn,
   input  logic              regWriteIn,
   input  logic [TNEW_W-1:0] tnewIn,
   output logic [REG_W-1:0]  writeRegQ,
   output logic              regWriteQ,
   output logic [TNEW_W-1:0] tnewQ
);
   import hazard_info_pipe_pkg::*;

   logic [TNEW_W-1:0] tnewNext;

   always_comb begin
      tnewNext = tnewIn;
      if (decEn) tnewNext = sat_dec(tnewIn);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         writeRegQ <= HAZ_BUBBLE.writeReg;
         regWriteQ <= HAZ_BUBBLE.regWrite;
         tnewQ     <= HAZ_BUBBLE.tnew;
      end else if (flush) begin
         writeRegQ <= HAZ_BUBBLE.writeReg;
         regWriteQ <= HAZ_BUBBLE.regWrite;
         tnewQ     <= HAZ_BUBBLE.tnew;
      end else begin
         writeRegQ <= writeRegIn;
         regWriteQ <= regWriteIn;
         tnewQ     <= tnewNext;
      end
   end

endmodule

// File: rtl/hazard_info_pipe.sv
// hazard_info_pipe
//   Carries each instruction's hazard descriptor from D through the E, M
//   and W pipeline registers for the hazard unit, and obeys its flushE by
//   loading bubbles into E. Every output comes straight from a flop.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     rsD, rtD, WriteRegD, RegWriteD, TnewD   descriptor decoded in D
//     flushE                     load a bubble into E
//     stallD                     D is stalled (statistics only)
//     rsE, rtE                   source registers of the instruction in E
//     WriteReg*/RegWrite*/Tnew*  destination descriptor in E, M and W
//     stall_cnt, bubble_cnt      statistics counters
//   Configuration:
//     HAZ_STAT_EN  when defined, stall_cnt/bubble_cnt count edges with
//                  stallD/flushE high and a simulation warning flags
//                  stallD without flushE. When undefined both read 0.
module hazard_info_pipe #(
   parameter int REG_W  = 5,
   parameter int TNEW_W = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  rsD,
   input  logic [REG_W-1:0]  rtD,
   input  logic [REG_W-1:0]  WriteRegD,
   input  logic              RegWriteD,
   input  logic [TNEW_W-1:0] TnewD,
   input  logic              flushE,
   input  logic              stallD,
   output logic [REG_W-1:0]  rsE,
   output logic [REG_W-1:0]  rtE,
   output logic [REG_W-1:0]  WriteRegE,
   output logic [REG_W-1:0]  WriteRegM,
   output logic [REG_W-1:0]  WriteRegW,
   output logic              RegWriteE,
   output logic              RegWriteM,
   output logic              RegWriteW,
   output logic [TNEW_W-1:0] TnewE,
   output logic [TNEW_W-1:0] TnewM,
   output logic [TNEW_W-1:0] TnewW,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);
   import hazard_info_pipe_pkg::*;

   // Writes to $0 are discarded by the register file, so they are
   // stripped here to keep them from ever matching a source register.
   logic              regWriteN;
   logic [REG_W-1:0]  writeRegN;
   logic [TNEW_W-1:0] tnewN;

   always_comb begin
      regWriteN = RegWriteD && (WriteRegD != '0);
      writeRegN = '0;
      tnewN     = '0;
      if (regWriteN) begin
         writeRegN = WriteRegD;
         tnewN     = TnewD;
      end
   end

   // Source registers are needed only in E, so they are kept here
   // rather than in the stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsE <= HAZ_BUBBLE.rs;
         rtE <= HAZ_BUBBLE.rt;
      end else if (flushE) begin
         rsE <= HAZ_BUBBLE.rs;
         rtE <= HAZ_BUBBLE.rt;
      end else begin
         rsE <= rsD;
         rtE <= rtD;
      end
   end

   // E keeps Tnew as decoded. M and W each remove one cycle.
   hazard_stage_reg #(.REG_W(REG_W), .TNEW_W(TNEW_W)) uStageE (
      .clk(clk), .rst_n(rst_n), .flush(flushE), .decEn(1'b0),
      .writeRegIn(writeRegN), .regWriteIn(regWriteN), .tnewIn(tnewN),
      .writeRegQ(WriteRegE), .regWriteQ(RegWriteE), .tnewQ(TnewE)
   );

   hazard_stage_reg #(.REG_W(REG_W), .TNEW_W(TNEW_W)) uStageM (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .decEn(1'b1),
      .writeRegIn(WriteRegE), .regWriteIn(RegWriteE), .tnewIn(TnewE),
      .writeRegQ(WriteRegM), .regWriteQ(RegWriteM), .tnewQ(TnewM)
   );

   hazard_stage_reg #(.REG_W(REG_W), .TNEW_W(TNEW_W)) uStageW (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .decEn(1'b1),
      .writeRegIn(WriteRegM), .regWriteIn(RegWriteM), .tnewIn(TnewM),
      .writeRegQ(WriteRegW), .regWriteQ(RegWriteW), .tnewQ(TnewW)
   );

`ifdef HAZ_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stallD) stall_cnt  <= stall_cnt + 1'b1;
         if (flushE) bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

`ifndef SYNTHESIS
   // A stalled D with an unflushed E duplicates the instruction in E.
   always_ff @(posedge clk) begin
      if (rst_n && stallD && !flushE)
         $warning("hazard_info_pipe: stallD without flushE");
   end
`endif
`else
   // stallD feeds only the statistics, which are not built here.
   logic unusedStallD;
   assign unusedStallD = stallD;
   assign stall_cnt    = '0;
   assign bubble_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_info_pipe.sv
module tb_hazard_info_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rsD = '0, rtD = '0, WriteRegD = '0;
   logic       RegWriteD = 1'b0;
   logic [1:0] TnewD = '0;
   logic       flushE = 1'b0, stallD = 1'b0;
   logic [4:0] rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic [1:0] TnewE, TnewM, TnewW;
   logic [31:0] stall_cnt, bubble_cnt;

   int vectors = 0;
   int miscompares = 0;

   hazard_info_pipe #(.REG_W(5), .TNEW_W(2), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .WriteRegD(WriteRegD),
      .RegWriteD(RegWriteD), .TnewD(TnewD), .flushE(flushE), .stallD(stallD),
      .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .WriteRegW(WriteRegW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .TnewE(TnewE), .TnewM(TnewM), .TnewW(TnewW),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // History of what entered E, oldest first: [0]=now in W, [1]=in M,
   // [2]=in E. Tnew seen k stages after E is max(Tnew-k, 0).
   typedef struct {
      int rs, rt, wr, rw, tn;
   } desc_t;

   desc_t hist[$];
   int    mStall = 0, mBubble = 0;

   function automatic desc_t bubble();
      desc_t d;
      d.rs = 0; d.rt = 0; d.wr = 0; d.rw = 0; d.tn = 0;
      return d;
   endfunction

   function automatic int after(input int tn, input int k);
      return (tn > k) ? tn - k : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist = {bubble(), bubble(), bubble()};
         mStall = 0;
         mBubble = 0;
      end else begin
         desc_t d;
         if (flushE) d = bubble();
         else begin
            d.rs = rsD; d.rt = rtD;
            if (RegWriteD && WriteRegD != 0) begin
               d.wr = WriteRegD; d.rw = 1; d.tn = TnewD;
            end else begin
               d.wr = 0; d.rw = 0; d.tn = 0;
            end
         end
         hist.push_back(d);
         void'(hist.pop_front());
         if (stallD) mStall++;
         if (flushE) mBubble++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic [33:0] act, exp;
      act = {rsE, rtE, WriteRegE, RegWriteE, TnewE,
             WriteRegM, RegWriteM, TnewM, WriteRegW, RegWriteW, TnewW};
      exp = {5'(hist[2].rs), 5'(hist[2].rt), 5'(hist[2].wr), 1'(hist[2].rw), 2'(hist[2].tn),
             5'(hist[1].wr), 1'(hist[1].rw), 2'(after(hist[1].tn, 1)),
             5'(hist[0].wr), 1'(hist[0].rw), 2'(after(hist[0].tn, 2))};
      chk("model_pipe", 64'(act), 64'(exp));
`ifdef HAZ_STAT_EN
      chk("model_cnt", {stall_cnt, bubble_cnt}, {32'(mStall), 32'(mBubble)});
`else
      chk("model_cnt", {stall_cnt, bubble_cnt}, 64'd0);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic step(input int rs, input int rt, input int wr, input int rw,
                       input int tn, input bit fl, input bit st);
      rsD = 5'(rs); rtD = 5'(rt); WriteRegD = 5'(wr);
      RegWriteD = 1'(rw); TnewD = 2'(tn); flushE = fl; stallD = st;
      @(posedge clk); #1;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   function automatic logic [63:0] stE();
      return 64'({WriteRegE, RegWriteE, TnewE});
   endfunction
   function automatic logic [63:0] stM();
      return 64'({WriteRegM, RegWriteM, TnewM});
   endfunction
   function automatic logic [63:0] stW();
      return 64'({WriteRegW, RegWriteW, TnewW});
   endfunction

   task automatic doReset();
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("reset_state", stE() | stM() | stW() | 64'({rsE, rtE}), 64'd0);

      // lw-style walk
      step(4, 6, 8, 1, 2, 1'b0, 1'b0);
      chk("lw_E", stE(), 64'({5'd8, 1'b1, 2'd2}));
      chk("lw_rsrtE", 64'({rsE, rtE}), 64'({5'd4, 5'd6}));
      nop();
      chk("lw_M", stM(), 64'({5'd8, 1'b1, 2'd1}));
      nop();
      chk("lw_W", stW(), 64'({5'd8, 1'b1, 2'd0}));

      // Saturation at Tnew=0
      step(0, 0, 5, 1, 0, 1'b0, 1'b0);
      chk("sat_E", stE(), 64'({5'd5, 1'b1, 2'd0}));
      nop();
      chk("sat_M", stM(), 64'({5'd5, 1'b1, 2'd0}));
      nop();
      chk("sat_W", stW(), 64'({5'd5, 1'b1, 2'd0}));

      // $0 destination normalisation
      step(1, 2, 0, 1, 3, 1'b0, 1'b0);
      chk("zero_E", stE(), 64'd0);
      // RegWrite low hides the destination too
      step(0, 0, 7, 0, 3, 1'b0, 1'b0);
      chk("nowr_E", stE(), 64'd0);

      // Back-to-back: three distinct descriptors in flight at once
      step(11, 12, 1, 1, 3, 1'b0, 1'b0);
      step(13, 14, 2, 1, 2, 1'b0, 1'b0);
      step(15, 16, 3, 1, 1, 1'b0, 1'b0);
      chk("b2b_E", stE(), 64'({5'd3, 1'b1, 2'd1}));
      chk("b2b_M", stM(), 64'({5'd2, 1'b1, 2'd1}));
      chk("b2b_W", stW(), 64'({5'd1, 1'b1, 2'd1}));

      // Async reset mid-cycle with a full pipeline
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", stE() | stM() | stW() | 64'({rsE, rtE}), 64'd0);
      // flushE during reset changes nothing
      flushE = 1'b1;
      @(posedge clk); #1;
      chk("rst_flush", stE() | stM(), 64'd0);
      flushE = 1'b0;
      rst_n = 1'b1;

      // Stall: older instruction keeps draining while E gets bubbles
      step(20, 21, 17, 1, 3, 1'b0, 1'b0);
      step(9, 3, 10, 1, 1, 1'b1, 1'b1);
      chk("stall1_E", stE() | 64'({rsE, rtE}), 64'd0);
      chk("stall1_M", stM(), 64'({5'd17, 1'b1, 2'd2}));
      step(9, 3, 10, 1, 1, 1'b1, 1'b1);
      chk("stall2_E", stE() | 64'({rsE, rtE}), 64'd0);
      chk("stall2_W", stW(), 64'({5'd17, 1'b1, 2'd1}));
      step(9, 3, 10, 1, 1, 1'b0, 1'b0);
      chk("stall_rel", 64'({rsE, rtE, WriteRegE, RegWriteE, TnewE}),
          64'({5'd9, 5'd3, 5'd10, 1'b1, 2'd1}));
`ifdef HAZ_STAT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'd2);
      chk("bubble_cnt", 64'(bubble_cnt), 64'd2);
`else
      chk("stall_cnt", 64'(stall_cnt), 64'd0);
      chk("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif

      // Protocol violation: stallD without flushE still loads D
      step(7, 8, 9, 1, 2, 1'b0, 1'b1);
      chk("viol_E", stE(), 64'({5'd9, 1'b1, 2'd2}));

      // Reset release: the first edge loads normally
      doReset();
      step(1, 1, 31, 1, 3, 1'b0, 1'b0);
      chk("post_rst_E", stE(), 64'({5'd31, 1'b1, 2'd3}));

      // Pseudo-random traffic checked by the model only
      for (int i = 0; i < 60; i++) begin
         step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0));
      end
      nop();
      nop();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_info_pipe.md
Name: hazard_info_pipe

Overview:
- Producer side of the hazard interface. Carries each instruction's hazard descriptor (rs, rt, destination register, RegWrite, Tnew) from D through the E, M and W pipeline registers.
- Presents the per-stage fields the hazard unit consumes: rsE/rtE, WriteReg*/RegWrite*/Tnew* for E, M and W.
- Obeys that unit's flushE output by inserting bubbles.
- Sits beside the datapath pipeline registers in the 5-stage MIPS core and is clocked identically.

Parameters:
- REG_W, 5, register-index width.
- TNEW_W, 2, Tnew field width.
- CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rsD  in  REG_W  rs field of the instruction in D.
- rtD  in  REG_W  rt field of the instruction in D.
- WriteRegD  in  REG_W  destination register decoded in D.
- RegWriteD  in  1  instruction in D writes the register file.
- TnewD  in  TNEW_W  cycles after entering E until the result exists (0..3).
- flushE  in  1  from hazard unit; load a bubble into E.
- stallD  in  1  from hazard unit; used for statistics and the protocol check only.
- rsE, rtE  out  REG_W each  registered rs/rt in E.
- WriteRegE, WriteRegM, WriteRegW  out  REG_W each  destination per stage.
- RegWriteE, RegWriteM, RegWriteW  out  1 each  write enable per stage.
- TnewE, TnewM, TnewW  out  TNEW_W each  remaining cycles per stage.
- stall_cnt  out  CNT_W  stall-cycle count (optional feature).
- bubble_cnt  out  CNT_W  flush-cycle count (optional feature).

Behaviour:
- Reset: every output is 0 while rst_n is low, asynchronously, with no clock needed. The pipeline holds all-bubble state.
- Normalisation at D: effective write enable = RegWriteD && (WriteRegD != 0). If the write enable is 0, the destination and Tnew are captured as 0.
- E register, each rising edge:
  - flushE=1: load bubble (rsE=rtE=0, WriteRegE=0, RegWriteE=0, TnewE=0).
  - Otherwise: load the normalised D fields. TnewE = TnewD.
- M register, each edge (never stalled or flushed): WriteRegM<=WriteRegE, RegWriteM<=RegWriteE, TnewM<=sat_dec(TnewE).
- W register, each edge: same form from M, TnewW<=sat_dec(TnewM).
- sat_dec(x) = (x==0) ? 0 : x-1. Never wraps.
- Latency: a descriptor appears in E one cycle after capture, in M after two, in W after three. A W entry is overwritten on the next edge.
- stallD=1 with flushE=1 (the normal stall case): E receives a bubble. D state is held by the datapath, so the same D fields are re-presented next cycle.
- stallD=1 with flushE=0 is a protocol violation. The block still loads D into E.
- Simultaneous flushE and reset: reset wins.
- Reset deasserted mid-operation: the first edge after release behaves as a normal cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: HAZ_STAT_EN.
- Defined:
  - stall_cnt increments on every edge with stallD=1.
  - bubble_cnt increments on every edge with flushE=1.
  - Both are CNT_W wide, wrap modulo 2^CNT_W, and reset to 0.
  - In simulation only, a display-time warning fires when stallD=1 and flushE=0.
- Undefined: stall_cnt and bubble_cnt are tied to 0 and no counter registers exist.

Decomposition:
- Shared package/header: REG_W and TNEW_W constants, the TNEW encodings (TNEW_0..TNEW_3), the bubble constant, and the sat_dec function.
- One sub-module, hazard_stage_reg: a single stage register carrying {WriteReg, RegWrite, Tnew}.
  - Inputs: flush and a decrement select.
  - Instantiated three times: E with decrement off, M and W with decrement on.
  - rsE/rtE live in the top module.

Test Plan:
- Reset: rst_n low mid-cycle with nonzero pipeline contents -> all outputs 0 immediately, before any clock edge.
- lw-style walk: D presents WriteRegD=8, RegWriteD=1, TnewD=2 for one cycle, then nops.
  - +1 cycle: E shows 8/1/2.
  - +2 cycles: M shows 8/1/1.
  - +3 cycles: W shows 8/1/0.
- Saturation: TnewD=0 with WriteRegD=5 -> TnewE=TnewM=TnewW=0, never 3.
- $0 normalisation: RegWriteD=1, WriteRegD=0, TnewD=3 -> E shows RegWriteE=0, WriteRegE=0, TnewE=0.
- Stall: stallD=flushE=1 for 2 cycles while D holds rs=9 -> E is a bubble for 2 cycles, then rsE=9. The older M/W contents keep draining. With HAZ_STAT_EN: stall_cnt=2, bubble_cnt=2.
- Back-to-back: three distinct instructions on consecutive cycles -> E, M and W each hold a different descriptor in the same cycle, with no cross-contamination.
